acc_unload: RTL and testbench

ACC_UNLOAD -- requirements
Module: acc_unload

---
 rtl/acc_unload_pkg.sv | 14 +
 rtl/acc_unload_beat_mux.sv | 23 ++
 rtl/acc_unload.sv | 102 ++++++++++
 tb/tb_acc_unload.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/acc_unload_pkg.sv
// Shared constants for the accumulator unload block: FSM state encoding
// and the helper that derives how many output beats make up one result.
package acc_unload_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unload_state_t;

    function automatic int calc_nbeats(input int acc_width, input int min_width);
        return acc_width / min_width;
    endfunction

endpackage

// File: rtl/acc_unload_beat_mux.sv
// Beat selector: picks chunk k (LSB chunk first) out of the stored result word.
module acc_beat_mux #(
    parameter int MIN_W  = 8,
    parameter int ACC_W  = 32,
    parameter int NBEATS = 4,
    parameter int KW     = 2
) (
    input  logic [ACC_W-1:0] word,
    input  logic [KW-1:0]    k,
    output logic [MIN_W-1:0] beat
);

    // Compare k against every legal index; out-of-range k yields zero.
    always_comb begin
        beat = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (k == KW'(i)) begin
                beat = word[i*MIN_W +: MIN_W];
            end
        end
    end

endmodule

// File: rtl/acc_unload.sv
// Accumulator unload: captures one wide MAC result (optionally saturated on
// carry) and streams it out as NBEATS narrow beats, LSB chunk first.
module acc_unload
    import acc_unload_pkg::*;
#(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MAC_ACC_WIDTH-1:0] in_data,
    input  logic                     in_carry,
    input  logic                     sat_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAC_MIN_WIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     out_ovf
);

    localparam int NBEATS = calc_nbeats(MAC_ACC_WIDTH, MAC_MIN_WIDTH);
    localparam int KW     = $clog2(NBEATS);
    localparam logic [KW-1:0] LAST_K = KW'(NBEATS - 1);

    unload_state_t            state;
    unload_state_t            next_state;
    logic [KW-1:0]            k;
    logic [MAC_ACC_WIDTH-1:0] word;
    logic                     ovf;
    logic [MAC_MIN_WIDTH-1:0] beat;
    logic                     capture;
    logic                     advance;

    acc_beat_mux #(
        .MIN_W  (MAC_MIN_WIDTH),
        .ACC_W  (MAC_ACC_WIDTH),
        .NBEATS (NBEATS),
        .KW     (KW)
    ) u_beat_mux (
        .word (word),
        .k    (k),
        .beat (beat)
    );

    // Handshake outputs and next state; a new result can be taken on the
    // same edge the final beat leaves, so results stream with no bubble.
    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        in_ready   = 1'b1;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (k == LAST_K);
                out_data  = beat;
                in_ready  = out_ready && (k == LAST_K);
                if (out_ready && (k == LAST_K) && !in_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign capture = in_valid && in_ready;
    assign advance = (state == SEND) && out_ready && (k != LAST_K);
    assign out_ovf = ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Result storage and beat index: reload on capture, step on accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            ovf  <= 1'b0;
            k    <= '0;
        end else if (capture) begin
            word <= (in_carry && sat_en) ? '1 : in_data;
            ovf  <= in_carry;
            k    <= '0;
        end else if (advance) begin
            k <= k + KW'(1);
        end
    end

endmodule

// File: tb/tb_acc_unload.sv
// Self-checking bench for acc_unload: directed scenarios plus random traffic,
// compared each cycle against a queue-of-beats reference model.
module tb_acc_unload;

    localparam int MIN_W = 8;
    localparam int ACC_W = 32;
    localparam int NB    = ACC_W / MIN_W;

    typedef struct {
        logic [MIN_W-1:0] data;
        logic             last;
        logic             ovf;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             in_carry;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [MIN_W-1:0] out_data;
    logic             out_last;
    logic             out_ovf;

    beat_t q[$];
    int    nCompared;
    int    nMismatched;

    acc_unload #(
        .MAC_MIN_WIDTH (MIN_W),
        .MAC_ACC_WIDTH (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, then let the
    // model consume/produce beats according to what transfers on the edge.
    task automatic applyStimulus(input logic iv, input logic [ACC_W-1:0] d,
                                 input logic c, input logic s, input logic ordy);
        logic             mReady;
        logic             mValid;
        logic [ACC_W-1:0] w;
        beat_t            b;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_carry  = c;
        sat_en    = s;
        out_ready = ordy;
        #1;
        mValid = (q.size() > 0);
        mReady = (q.size() == 0) || (q.size() == 1 && ordy);
        checkOutput("out_valid", out_valid, mValid);
        checkOutput("in_ready", in_ready, mReady);
        if (mValid) begin
            checkOutput("out_data", out_data, q[0].data);
            checkOutput("out_last", out_last, q[0].last);
            checkOutput("out_ovf", out_ovf, q[0].ovf);
        end
        @(posedge clk);
        if (mValid && ordy) begin
            void'(q.pop_front());
        end
        if (mReady && iv) begin
            w = (c && s) ? {ACC_W{1'b1}} : d;
            for (int i = 0; i < NB; i++) begin
                b.data = w[i*MIN_W +: MIN_W];
                b.last = (i == NB - 1);
                b.ovf  = c;
                q.push_back(b);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < NB + 2; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_data"}, out_data, '0);
        checkOutput({tag, "_last"}, out_last, 1'b0);
        checkOutput({tag, "_ovf"}, out_ovf, 1'b0);
        checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_carry  = 1'b0;
        sat_en    = 1'b0;
        out_ready = 1'b0;
        #12;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain result, full throughput.
        applyStimulus(1'b1, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b1);
        drain();

        // Carry with and without saturation.
        applyStimulus(1'b1, 32'h0000_0012, 1'b1, 1'b1, 1'b1);
        drain();
        applyStimulus(1'b1, 32'h0000_0012, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back results with in_valid held.
        applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
        end
        drain();

        // Stall pattern 1,0,0,1 with in_valid offered during stalls.
        applyStimulus(1'b1, 32'hA1B2_C3D4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 32'h5566_7788, 1'b1, 1'b1, (i % 3) == 0);
        end
        drain();

        // Reset after two beats of a result have gone out.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h0102_0304, 1'b0, 1'b0, 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ACC_W'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
